// File: rtl/bram_burst_pkg.sv
// Shared constants and types for the BRAM burst read engine.
// Defining BRAM_OUT_REG_EN selects the 2-cycle read latency of a BRAM built with its output register.
package bram_burst_pkg;

    localparam int DATA_W = 512;
    localparam int ADDR_W = 12;

`ifdef BRAM_OUT_REG_EN
    localparam int RD_LAT = 2;
`else
    localparam int RD_LAT = 1;
`endif

    // Every in-flight read, the word being drained and the word landing must all have a slot.
    localparam int MIN_FIFO_DEPTH = RD_LAT + 2;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/bram_burst_reader_if.sv
// Valid/ready word stream with last marker, from the burst reader to the downstream packer.
interface bram_burst_reader_if #(
    parameter int DATA_W = bram_burst_pkg::DATA_W
);
    logic              valid;
    logic              ready;
    logic              last;
    logic [DATA_W-1:0] data;

    modport master (output valid, last, data, input ready);
    modport slave  (input valid, last, data, output ready);
endinterface

// File: rtl/burst_fifo.sv
// Synchronous FIFO absorbing BRAM read latency; the occupancy count feeds the issue credit check.
module burst_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 512,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic [CNT_W-1:0] count
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             do_wr;
    logic             do_rd;

    // Depth need not be a power of two, so pointers wrap explicitly.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= ptr_inc(wr_ptr);
            if (do_rd) rd_ptr <= ptr_inc(rd_ptr);
            case ({do_wr, do_rd})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/bram_burst_reader.sv
// Burst read engine: issues credit-limited BRAM reads and streams the words out with a last marker.
// Read latency follows BRAM_OUT_REG_EN (see bram_burst_pkg).
module bram_burst_reader #(
    parameter int DATA_W     = bram_burst_pkg::DATA_W,
    parameter int ADDR_W     = bram_burst_pkg::ADDR_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [ADDR_W-1:0]   cmd_len,
    output logic                bram_en,
    output logic                bram_we,
    output logic [ADDR_W-1:0]   bram_addr,
    input  logic [DATA_W-1:0]   bram_dout,
    bram_burst_reader_if.master m,
    output logic                busy,
    output logic                done
);
    import bram_burst_pkg::*;

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    if (FIFO_DEPTH < MIN_FIFO_DEPTH) begin : g_depth_chk
        $error("bram_burst_reader: FIFO_DEPTH too small for the configured read latency");
    end

    state_e              state;
    logic                ready_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [ADDR_W-1:0]   addr_hold;
    logic [ADDR_W:0]     iss_cnt;
    logic [ADDR_W:0]     rcv_cnt;
    logic [RD_LAT-1:0]   vld_pipe;
    logic [CNT_W-1:0]    fifo_cnt;
    logic [CNT_W:0]      credits_used;
    logic [DATA_W-1:0]   fifo_head;
    logic                fifo_empty;
    logic                fifo_wr;
    logic                issue;
    logic                pop;

    always_comb begin
        credits_used = (CNT_W + 1)'(fifo_cnt);
        for (int i = 0; i < RD_LAT; i++) begin
            credits_used = credits_used + (CNT_W + 1)'(vld_pipe[i]);
        end
    end

    assign issue     = (state == RUN) && (iss_cnt != '0) &&
                       (credits_used < (CNT_W + 1)'(FIFO_DEPTH));
    assign bram_en   = issue;
    assign bram_we   = 1'b0;
    assign bram_addr = issue ? addr_q : addr_hold;

    // The oldest pipeline stage marks bram_dout as valid this cycle.
    assign fifo_wr = vld_pipe[RD_LAT-1];

    assign m.valid   = !fifo_empty;
    assign m.data    = m.valid ? fifo_head : '0;
    assign m.last    = m.valid && (rcv_cnt == (ADDR_W + 1)'(1));
    assign pop       = m.valid && m.ready;
    assign done      = pop && m.last;
    assign busy      = (state == RUN);
    assign cmd_ready = (state == IDLE) && ready_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[0] <= issue;
            for (int i = 1; i < RD_LAT; i++) vld_pipe[i] <= vld_pipe[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ready_q   <= 1'b0;
            addr_q    <= '0;
            addr_hold <= '0;
            iss_cnt   <= '0;
            rcv_cnt   <= '0;
        end else begin
            ready_q <= 1'b1;
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        state   <= RUN;
                        addr_q  <= cmd_addr;
                        iss_cnt <= {1'b0, cmd_len} + (ADDR_W + 1)'(1);
                        rcv_cnt <= {1'b0, cmd_len} + (ADDR_W + 1)'(1);
                    end
                end
                RUN: begin
                    if (issue) begin
                        addr_hold <= addr_q;
                        addr_q    <= addr_q + ADDR_W'(1);
                        iss_cnt   <= iss_cnt - (ADDR_W + 1)'(1);
                    end
                    if (pop) rcv_cnt <= rcv_cnt - (ADDR_W + 1)'(1);
                    // The receive count, not the issue count, decides when the burst is over.
                    if (done) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    burst_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (fifo_wr),
        .wr_data (bram_dout),
        .rd_en   (pop),
        .rd_data (fifo_head),
        .empty   (fifo_empty),
        .count   (fifo_cnt)
    );

endmodule

// File: tb/tb_bram_burst_reader.sv
// Scoreboard bench for bram_burst_reader: behavioural BRAM, expected words queued at command accept.
module tb_bram_burst_reader;
    localparam int FIFO_DEPTH = 4;
`ifdef BRAM_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    typedef struct {
        logic [511:0] data;
        logic         last;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         cmd_valid, cmd_ready, bram_en, bram_we, busy, done;
    logic [11:0]  cmd_addr, cmd_len, bram_addr;
    logic [511:0] bram_dout, rd1, rd2;

    bram_burst_reader_if #(.DATA_W(512)) sif ();

    bram_burst_reader #(.DATA_W(512), .ADDR_W(12), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .bram_en   (bram_en),
        .bram_we   (bram_we),
        .bram_addr (bram_addr),
        .bram_dout (bram_dout),
        .m         (sif),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    function automatic logic [511:0] pat(input logic [11:0] a);
        return {16{4'hA, a, 4'h5, ~a}};
    endfunction

    // Behavioural BRAM port: contents are a function of the address.
    always @(posedge clk) if (bram_en) rd1 <= pat(bram_addr);
`ifdef BRAM_OUT_REG_EN
    always @(posedge clk) rd2 <= rd1;
    assign bram_dout = rd2;
`else
    assign rd2 = '0;
    assign bram_dout = rd1;
`endif

    int n_chk = 0, n_fail = 0;
    int cyc = 0, t0 = 0, hs_abs = 0, done_abs = 0, n_done = 0;
    int first_en = -1, last_en = -1, en_cnt = 0, first_valid = -1, last_hs = -1;
    int ready_cyc = -1, n_words = 0, en_before_pop = 0, k = 0;
    bit popped = 0, prev_stall = 0;
    logic [511:0] prev_data;
    logic         prev_last;
    logic [11:0]  exp_addr;
    exp_t         sb[$];
    exp_t         e;

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 0;
        end else begin
            if (cmd_valid && cmd_ready) begin
                t0 = cyc; hs_abs = cyc;
                first_en = -1; last_en = -1; en_cnt = 0; first_valid = -1; last_hs = -1;
                ready_cyc = -1; n_words = 0; en_before_pop = 0; popped = 0;
                exp_addr = cmd_addr;
                for (int i = 0; i <= int'(cmd_len); i++)
                    sb.push_back('{pat(cmd_addr + 12'(i)), i == int'(cmd_len)});
            end else if (cmd_ready && ready_cyc < 0) begin
                ready_cyc = cyc - t0;
            end
            k = cyc - t0;
            if (bram_en) begin
                chk("bram_addr", 512'(bram_addr), 512'(exp_addr));
                chk("bram_we", 512'(bram_we), 512'(0));
                exp_addr = exp_addr + 12'd1;
                en_cnt++;
                if (first_en < 0) first_en = k;
                last_en = k;
                if (!popped) en_before_pop++;
            end
            if (sif.valid && first_valid < 0) first_valid = k;
            if (prev_stall) begin
                chk("hold_valid", 512'(sif.valid), 512'(1));
                chk("hold_data", sif.data, prev_data);
                chk("hold_last", 512'(sif.last), 512'(prev_last));
            end
            if (dut.fifo_wr)
                chk("fifo_overflow", 512'(dut.u_fifo.full && !dut.u_fifo.do_rd), 512'(0));
            if (sif.valid && sif.ready) begin
                popped = 1;
                n_words++;
                chk("sb_nonempty", 512'(sb.size() != 0), 512'(1));
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("m_data", sif.data, e.data);
                    chk("m_last", 512'(sif.last), 512'(e.last));
                    chk("done_on_last", 512'(done), 512'(e.last));
                    if (e.last) last_hs = k;
                end
            end
            if (done) begin
                chk("done_with_hs", 512'(sif.valid && sif.ready), 512'(1));
                n_done++;
                done_abs = cyc;
            end
            prev_stall = sif.valid && !sif.ready;
            prev_data  = sif.data;
            prev_last  = sif.last;
        end
    end

    task automatic wait_hs();
        int n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 10000) begin
            @(negedge clk);
            n++;
        end
        chk("cmd_accept", 512'(cmd_ready), 512'(1));
        @(posedge clk); #1;
    endtask

    task automatic wait_done(input int budget);
        int d0 = n_done;
        int n = 0;
        while (n_done == d0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", 512'(n_done != d0), 512'(1));
    endtask

    task automatic settle();
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
    endtask

    task automatic send(input logic [11:0] a, input logic [11:0] l);
        cmd_addr = a; cmd_len = l; cmd_valid = 1'b1;
        wait_hs();
        cmd_valid = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; sif.ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cmd_ready", 512'(cmd_ready), 512'(0));
        chk("rst_bram_en", 512'(bram_en), 512'(0));
        chk("rst_bram_addr", 512'(bram_addr), 512'(0));
        chk("rst_m_valid", 512'(sif.valid), 512'(0));
        chk("rst_m_data", sif.data, 512'(0));
        chk("rst_m_last", 512'(sif.last), 512'(0));
        chk("rst_busy", 512'(busy), 512'(0));
        chk("rst_done", 512'(done), 512'(0));
        @(negedge clk) rst_n = 1'b1;
        #1 chk("rdy_before_edge", 512'(cmd_ready), 512'(0));
        @(negedge clk);
        chk("rdy_after_release", 512'(cmd_ready), 512'(1));
        @(posedge clk); #1;

        // single word
        sif.ready = 1'b1;
        send(12'h010, 12'd0);
        wait_done(100);
        settle();
        chk("single_first_en", 512'(first_en), 512'(1));
        chk("single_en_cnt", 512'(en_cnt), 512'(1));
        chk("single_first_valid", 512'(first_valid), 512'(LAT + 2));
        chk("single_last_hs", 512'(last_hs), 512'(LAT + 2));
        chk("single_ready_back", 512'(ready_cyc), 512'(LAT + 3));
        chk("single_words", 512'(n_words), 512'(1));

        // address wrap
        send(12'hFFC, 12'd7);
        wait_done(100);
        settle();
        chk("wrap_first_en", 512'(first_en), 512'(1));
        chk("wrap_last_en", 512'(last_en), 512'(8));
        chk("wrap_en_cnt", 512'(en_cnt), 512'(8));
        chk("wrap_last_hs", 512'(last_hs), 512'(9 + LAT));
        chk("wrap_words", 512'(n_words), 512'(8));

        // backpressure
        sif.ready = 1'b0;
        send(12'h100, 12'd15);
        d0 = n_done;
        for (int n = 0; n < 300 && n_done == d0; n++) begin
            sif.ready = ((cyc - t0) >= 10) && ((cyc - t0) % 2 == 0);
            @(posedge clk); #1;
        end
        chk("bp_done_seen", 512'(n_done != d0), 512'(1));
        sif.ready = 1'b1;
        settle();
        chk("bp_en_before_pop", 512'(en_before_pop), 512'(FIFO_DEPTH));
        chk("bp_en_cnt", 512'(en_cnt), 512'(16));
        chk("bp_words", 512'(n_words), 512'(16));

        // full address space
        d0 = n_done;
        send(12'h000, 12'd4095);
        wait_done(5000);
        settle();
        chk("full_last_hs", 512'(last_hs), 512'(4097 + LAT));
        chk("full_words", 512'(n_words), 512'(4096));
        chk("full_done_once", 512'(n_done - d0), 512'(1));

        // back-to-back commands
        cmd_addr = 12'h200; cmd_len = 12'd3; cmd_valid = 1'b1;
        wait_hs();
        cmd_addr = 12'h280; cmd_len = 12'd2;
        wait_hs();
        cmd_valid = 1'b0;
        chk("b2b_accept_gap", 512'(hs_abs - done_abs), 512'(1));
        wait_done(100);
        settle();
        chk("b2b_words", 512'(n_words), 512'(3));

        // reset mid-burst
        send(12'h300, 12'd15);
        while (cyc - t0 < 6) begin
            @(posedge clk); #1;
        end
        d0 = n_done;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_m_valid", 512'(sif.valid), 512'(0));
        chk("mid_rst_busy", 512'(busy), 512'(0));
        chk("mid_rst_bram_en", 512'(bram_en), 512'(0));
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_no_done", 512'(n_done), 512'(d0));
        send(12'h7FE, 12'd1);
        wait_done(100);
        settle();
        chk("post_rst_words", 512'(n_words), 512'(2));
        chk("post_rst_done_once", 512'(n_done - d0), 512'(1));
        chk("sb_drained", 512'(sb.size()), 512'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
